// File: rtl/clint.sv
// Core-local interrupt/trap controller: detects ecall/ebreak/mret/external interrupts,
// sequences mepc/mcause/mstatus CSR writes, then redirects the PC. Option: CLINT_VECTORED_EN.
module clint #(
  parameter int          INT_W     = 8,
  parameter logic [31:0] CAUSE_EXT = 32'h8000000B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_flag_i,
  input  logic             ex_csr_we_i,
  input  logic             global_int_en_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  output logic             csr_we_o,
  output logic [31:0]      csr_waddr_o,
  output logic [31:0]      csr_wdata_o,
  output logic             hold_flag_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h00000073;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;
  localparam logic [31:0] INST_MRET   = 32'h30200073;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    W_MRET,
    ASSERT
  } state_t;

  state_t      state;
  logic [31:0] mepc_q;
  logic [31:0] cause_q;
  logic [31:0] target_q;
  logic [31:0] trap_target;
  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;
  logic        async_req;
  logic        detect;
  logic        write_state;
  logic        unused_inputs;

  // The redirect target is taken from the decode path only; execute redirects just suppress detection.
  assign unused_inputs = ^jump_addr_i;

  assign is_ecall    = (inst_i == INST_ECALL);
  assign is_ebreak   = (inst_i == INST_EBREAK);
  assign is_mret     = (inst_i == INST_MRET);
  assign async_req   = (|int_flag_i) & global_int_en_i & ~hold_flag_i;
  assign detect      = (state == IDLE) & ~rst & ~jump_flag_i & (is_ecall | is_ebreak | is_mret | async_req);
  assign write_state = (state inside {W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET});

  assign csr_we_o     = write_state & ~ex_csr_we_i & ~rst;
  assign hold_flag_o  = ~rst & (detect | (state != IDLE));
  assign int_assert_o = ~rst & (state == ASSERT);
  assign int_addr_o   = int_assert_o ? target_q : 32'h0;

  always_comb begin
    trap_target = csr_mtvec_i;
`ifdef CLINT_VECTORED_EN
    // Only asynchronous causes (bit 31 set) use the vector table; sync traps land on the base.
    trap_target = {csr_mtvec_i[31:2], 2'b00};
    if (csr_mtvec_i[1:0] == 2'b01 && cause_q[31])
      trap_target = {csr_mtvec_i[31:2], 2'b00} + {cause_q[28:0], 2'b00};
`endif
  end

  // mstatus is taken live from the CSR file in the write cycle itself.
  always_comb begin
    csr_waddr_o = 32'h0;
    csr_wdata_o = 32'h0;
    case (state)
      W_MEPC: begin
        csr_waddr_o = 32'h341;
        csr_wdata_o = mepc_q;
      end
      W_MCAUSE: begin
        csr_waddr_o = 32'h342;
        csr_wdata_o = cause_q;
      end
      W_MSTATUS: begin
        csr_waddr_o    = 32'h300;
        csr_wdata_o    = csr_mstatus_i;
        csr_wdata_o[7] = csr_mstatus_i[3];
        csr_wdata_o[3] = 1'b0;
      end
      W_MRET: begin
        csr_waddr_o    = 32'h300;
        csr_wdata_o    = csr_mstatus_i;
        csr_wdata_o[3] = csr_mstatus_i[7];
        csr_wdata_o[7] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mepc_q   <= 32'h0;
      cause_q  <= 32'h0;
      target_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (!jump_flag_i) begin
            if (is_ecall) begin
              mepc_q  <= inst_addr_i;
              cause_q <= 32'd11;
              state   <= W_MEPC;
            end else if (is_ebreak) begin
              mepc_q  <= inst_addr_i;
              cause_q <= 32'd3;
              state   <= W_MEPC;
            end else if (is_mret) begin
              state <= W_MRET;
            end else if (async_req) begin
              mepc_q  <= inst_addr_i;
              cause_q <= CAUSE_EXT;
              state   <= W_MEPC;
            end
          end
        end
        // Each write state holds while execute owns the CSR port, so no write is dropped.
        W_MEPC: if (!ex_csr_we_i) state <= W_MCAUSE;
        W_MCAUSE: if (!ex_csr_we_i) state <= W_MSTATUS;
        W_MSTATUS: begin
          if (!ex_csr_we_i) begin
            target_q <= trap_target;
            state    <= ASSERT;
          end
        end
        W_MRET: begin
          if (!ex_csr_we_i) begin
            target_q <= csr_mepc_i;
            state    <= ASSERT;
          end
        end
        ASSERT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: per-cycle stimulus tables feed a scoreboard queue of
// expected outputs, compared on the falling edge inside each scenario task.
module tb_clint;

  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] MRET   = 32'h30200073;
  localparam logic [31:0] NOP    = 32'h00000013;
`ifdef CLINT_VECTORED_EN
  localparam logic [31:0] VEC_ASYNC = 32'h000000AC;
  localparam logic [31:0] VEC_SYNC  = 32'h00000080;
`else
  localparam logic [31:0] VEC_ASYNC = 32'h00000081;
  localparam logic [31:0] VEC_SYNC  = 32'h00000081;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_flag;
  logic [31:0] inst, inst_addr, jump_addr, mtvec, mepc, mstatus;
  logic        jump_flag, hold_in, ex_we, gie;
  logic        csr_we, hold_out, int_assert;
  logic [31:0] csr_waddr, csr_wdata, int_addr;

  typedef struct {
    logic        rst;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        jump;
    logic        hold;
    logic        ex_we;
    logic        gie;
    logic [7:0]  irq;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mstatus;
  } stim_t;

  typedef struct packed {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        hold;
    logic        as;
    logic [31:0] addr;
  } obs_t;

  typedef struct {
    stim_t s;
    obs_t  e;
  } vec_t;

  vec_t plan[$];
  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  clint #(.INT_W(8), .CAUSE_EXT(32'h8000000B)) dut (
    .clk(clk), .rst(rst), .int_flag_i(int_flag), .inst_i(inst), .inst_addr_i(inst_addr),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .hold_flag_i(hold_in),
    .ex_csr_we_i(ex_we), .global_int_en_i(gie), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
    .csr_mstatus_i(mstatus), .csr_we_o(csr_we), .csr_waddr_o(csr_waddr),
    .csr_wdata_o(csr_wdata), .hold_flag_o(hold_out), .int_assert_o(int_assert),
    .int_addr_o(int_addr)
  );

  always #5 clk = ~clk;

  function automatic stim_t dflt(logic [31:0] i, logic [31:0] a);
    stim_t s;
    s.rst = 1'b0; s.inst = i; s.addr = a; s.jump = 1'b0; s.hold = 1'b0; s.ex_we = 1'b0;
    s.gie = 1'b0; s.irq = 8'h0; s.mtvec = 32'h80; s.mepc = 32'h104; s.mstatus = 32'h8;
    return s;
  endfunction

  function automatic obs_t exv(logic we, logic [31:0] wa, logic [31:0] wd, logic h, logic as, logic [31:0] ad);
    obs_t o;
    o.we = we; o.waddr = wa; o.wdata = wd; o.hold = h; o.as = as; o.addr = ad;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.we = csr_we; o.waddr = csr_waddr; o.wdata = csr_wdata;
    o.hold = hold_out; o.as = int_assert; o.addr = int_addr;
    if (!csr_we) begin o.waddr = '0; o.wdata = '0; end
    return o;
  endfunction

  task automatic drive(stim_t s);
    rst = s.rst; inst = s.inst; inst_addr = s.addr; jump_flag = s.jump; hold_in = s.hold;
    ex_we = s.ex_we; gie = s.gie; int_flag = s.irq; mtvec = s.mtvec; mepc = s.mepc;
    mstatus = s.mstatus; jump_addr = 32'hDEAD0000;
  endtask

  task automatic add(stim_t s, obs_t e);
    vec_t v;
    v.s = s; v.e = e;
    plan.push_back(v);
  endtask

  task automatic test_reset();
    stim_t s;
    obs_t got, want;
    vec_t v;
    int cyc = 0;
    s = dflt(ECALL, 32'h10); s.rst = 1'b1; add(s, exv(0, 0, 0, 0, 0, 0));
    add(s, exv(0, 0, 0, 0, 0, 0));
    add(dflt(NOP, 32'h14), exv(0, 0, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      v = plan.pop_front(); drive(v.s); exp_q.push_back(v.e);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL reset cyc%0d got %h want %h", cyc, got, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap_entry();
    stim_t s;
    obs_t got, want;
    vec_t v;
    int cyc = 0;
    add(dflt(ECALL, 32'h100), exv(0, 0, 0, 1, 0, 0));
    add(dflt(NOP, 32'h104), exv(1, 32'h341, 32'h100, 1, 0, 0));
    add(dflt(NOP, 32'h104), exv(1, 32'h342, 32'd11, 1, 0, 0));
    add(dflt(NOP, 32'h104), exv(1, 32'h300, 32'h80, 1, 0, 0));
    add(dflt(NOP, 32'h104), exv(0, 0, 0, 1, 1, 32'h80));
    add(dflt(NOP, 32'h80), exv(0, 0, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      v = plan.pop_front(); drive(v.s); exp_q.push_back(v.e);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL trap_entry cyc%0d got %h want %h", cyc, got, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ebreak();
    stim_t s;
    obs_t got, want;
    vec_t v;
    int cyc = 0;
    s = dflt(EBREAK, 32'h104); s.mtvec = 32'h81; s.mstatus = 32'h0;
    add(s, exv(0, 0, 0, 1, 0, 0));
    s.inst = NOP;
    add(s, exv(1, 32'h341, 32'h104, 1, 0, 0));
    add(s, exv(1, 32'h342, 32'd3, 1, 0, 0));
    add(s, exv(1, 32'h300, 32'h0, 1, 0, 0));
    add(s, exv(0, 0, 0, 1, 1, VEC_SYNC));
    add(s, exv(0, 0, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      v = plan.pop_front(); drive(v.s); exp_q.push_back(v.e);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL ebreak cyc%0d got %h want %h", cyc, got, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mret();
    stim_t s;
    obs_t got, want;
    vec_t v;
    int cyc = 0;
    s = dflt(MRET, 32'h180); s.mstatus = 32'h80; s.mepc = 32'h104;
    add(s, exv(0, 0, 0, 1, 0, 0));
    s.inst = NOP;
    add(s, exv(1, 32'h300, 32'h88, 1, 0, 0));
    add(s, exv(0, 0, 0, 1, 1, 32'h104));
    add(s, exv(0, 0, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      v = plan.pop_front(); drive(v.s); exp_q.push_back(v.e);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL mret cyc%0d got %h want %h", cyc, got, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_hold();
    stim_t s;
    obs_t got, want;
    vec_t v;
    int cyc = 0;
    s = dflt(NOP, 32'h200); s.irq = 8'h01; s.gie = 1'b1; s.hold = 1'b1;
    for (int i = 0; i < 3; i++) add(s, exv(0, 0, 0, 0, 0, 0));
    s.hold = 1'b0;
    add(s, exv(0, 0, 0, 1, 0, 0));
    s.gie = 1'b0;
    add(s, exv(1, 32'h341, 32'h200, 1, 0, 0));
    add(s, exv(1, 32'h342, 32'h8000000B, 1, 0, 0));
    add(s, exv(1, 32'h300, 32'h80, 1, 0, 0));
    add(s, exv(0, 0, 0, 1, 1, 32'h80));
    add(s, exv(0, 0, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      v = plan.pop_front(); drive(v.s); exp_q.push_back(v.e);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL async_hold cyc%0d got %h want %h", cyc, got, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_stall();
    stim_t s;
    obs_t got, want;
    vec_t v;
    int cyc = 0;
    // An interrupt is pending too, so the ecall must win the cause.
    s = dflt(ECALL, 32'h300); s.irq = 8'h80; s.gie = 1'b1;
    add(s, exv(0, 0, 0, 1, 0, 0));
    s.inst = NOP; s.gie = 1'b0;
    add(s, exv(1, 32'h341, 32'h300, 1, 0, 0));
    s.ex_we = 1'b1;
    add(s, exv(0, 0, 0, 1, 0, 0));
    add(s, exv(0, 0, 0, 1, 0, 0));
    s.ex_we = 1'b0;
    add(s, exv(1, 32'h342, 32'd11, 1, 0, 0));
    add(s, exv(1, 32'h300, 32'h80, 1, 0, 0));
    add(s, exv(0, 0, 0, 1, 1, 32'h80));
    add(s, exv(0, 0, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      v = plan.pop_front(); drive(v.s); exp_q.push_back(v.e);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL write_stall cyc%0d got %h want %h", cyc, got, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_reset();
    stim_t s;
    obs_t got, want;
    vec_t v;
    int cyc = 0;
    s = dflt(ECALL, 32'h3F0); s.jump = 1'b1;
    add(s, exv(0, 0, 0, 0, 0, 0));
    add(dflt(NOP, 32'h3F4), exv(0, 0, 0, 0, 0, 0));
    add(dflt(ECALL, 32'h400), exv(0, 0, 0, 1, 0, 0));
    add(dflt(NOP, 32'h404), exv(1, 32'h341, 32'h400, 1, 0, 0));
    s = dflt(NOP, 32'h404); s.rst = 1'b1;
    add(s, exv(0, 0, 0, 0, 0, 0));
    add(dflt(NOP, 32'h404), exv(0, 0, 0, 0, 0, 0));
    add(dflt(NOP, 32'h404), exv(0, 0, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      v = plan.pop_front(); drive(v.s); exp_q.push_back(v.e);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL flush_reset cyc%0d got %h want %h", cyc, got, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_vectored();
    stim_t s;
    obs_t got, want;
    vec_t v;
    int cyc = 0;
    s = dflt(NOP, 32'h500); s.mtvec = 32'h81; s.irq = 8'h04; s.gie = 1'b1;
    add(s, exv(0, 0, 0, 1, 0, 0));
    s.gie = 1'b0;
    add(s, exv(1, 32'h341, 32'h500, 1, 0, 0));
    add(s, exv(1, 32'h342, 32'h8000000B, 1, 0, 0));
    add(s, exv(1, 32'h300, 32'h80, 1, 0, 0));
    add(s, exv(0, 0, 0, 1, 1, VEC_ASYNC));
    add(s, exv(0, 0, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      v = plan.pop_front(); drive(v.s); exp_q.push_back(v.e);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL vectored cyc%0d got %h want %h", cyc, got, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    obs_t got, want;
    vec_t v;
    int cyc = 0;
    s = dflt(MRET, 32'h5F0); s.mstatus = 32'h80; s.mepc = 32'h600;
    add(s, exv(0, 0, 0, 1, 0, 0));
    s.inst = NOP;
    add(s, exv(1, 32'h300, 32'h88, 1, 0, 0));
    // ecall already in decode during ASSERT must wait for IDLE.
    s.inst = ECALL; s.mstatus = 32'h88;
    add(s, exv(0, 0, 0, 1, 1, 32'h600));
    add(s, exv(0, 0, 0, 1, 0, 0));
    s.inst = NOP;
    add(s, exv(1, 32'h341, 32'h5F0, 1, 0, 0));
    add(s, exv(1, 32'h342, 32'd11, 1, 0, 0));
    add(s, exv(1, 32'h300, 32'h80, 1, 0, 0));
    add(s, exv(0, 0, 0, 1, 1, 32'h80));
    add(s, exv(0, 0, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      v = plan.pop_front(); drive(v.s); exp_q.push_back(v.e);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL back_to_back cyc%0d got %h want %h", cyc, got, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    stim_t s;
    s = dflt(NOP, 32'h0); s.rst = 1'b1;
    drive(s);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_trap_entry();
    test_ebreak();
    test_mret();
    test_async_hold();
    test_write_stall();
    test_flush_reset();
    test_vectored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
